// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path.
//   seqState_e    : fetch/sequence FSM states
//   PC_W_DEFAULT  : default program counter / instruction address width
//   PC_RESET      : PC value after reset
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT = 8;

  localparam logic [PC_W_DEFAULT-1:0] PC_RESET = '0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StExec,
    StHalted
  } seqState_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset to PC_RESET
//   incEn   : advance PC by one (wraps modulo 2^PC_W)
//   loadEn  : load loadVal
//   loadVal : value to load
//   pc      : current PC
// Callers never assert incEn and loadEn together; load is given priority anyway.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            incEn,
  input  logic            loadEn,
  input  logic [PC_W-1:0] loadVal,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pcQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcQ <= PC_W'(PC_RESET);
    end else if (loadEn) begin
      pcQ <= loadVal;
    end else if (incEn) begin
      pcQ <= pcQ + PC_W'(1);
    end
  end

  assign pc = pcQ;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing for the accumulator CPU.
//   clk, reset           : clock and synchronous active-high reset
//   run                  : start/continue fetching, sampled at instruction boundaries
//   imem_req/addr/ack/data : instruction memory handshake (addr always equals pc)
//   instruction, LoadIR  : captured byte and one-cycle IR load strobe
//   exec_start/exec_done : execute controller handshake
//   jump_en, jump_cond, acc_zero, jump_target, halt : next-PC resolution, qualified by exec_done
//   pc, busy, halted     : status
// All control outputs are decoded from registered state, so no input reaches them
// combinationally.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [7:0]      instruction,
  output logic            LoadIR,
  output logic            exec_start,
  input  logic            exec_done,
  input  logic            jump_en,
  input  logic            jump_cond,
  input  logic            acc_zero,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  seqState_e stateQ;
  logic [7:0] instrQ;
  logic       execFirstQ;
  logic       pcInc;
  logic       jumpTaken;

  // Halt takes precedence, so a halting instruction never moves the PC.
  always_comb begin
    pcInc     = (stateQ == StLoad);
    jumpTaken = (stateQ == StExec) && exec_done && !halt && jump_en &&
                (!jump_cond || acc_zero);
  end

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .incEn  (pcInc),
    .loadEn (jumpTaken),
    .loadVal(jump_target),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      instrQ     <= 8'h00;
      execFirstQ <= 1'b0;
    end else begin
      execFirstQ <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (run) stateQ <= StFetch;
        end
        StFetch: begin
          if (imem_ack) begin
            instrQ <= imem_data;
            stateQ <= StLoad;
          end
        end
        StLoad: begin
          stateQ     <= StExec;
          execFirstQ <= 1'b1;
        end
        StExec: begin
          if (exec_done) begin
            if (halt)     stateQ <= StHalted;
            else if (run) stateQ <= StFetch;
            else          stateQ <= StIdle;
          end
        end
        StHalted: begin
          stateQ <= StHalted;
        end
        default: begin
          stateQ <= StIdle;
        end
      endcase
    end
  end

  assign imem_req    = (stateQ == StFetch);
  assign imem_addr   = pc;
  assign instruction = instrQ;
  assign LoadIR      = (stateQ == StLoad);
  assign exec_start  = execFirstQ;
  assign busy        = (stateQ != StIdle) && (stateQ != StHalted);
  assign halted      = (stateQ == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, imem_ack, exec_done, jump_en, jump_cond, acc_zero, halt;
  logic [7:0] imem_data, jump_target;
  logic       imem_req, LoadIR, exec_start, busy, halted;
  logic [7:0] imem_addr, instruction, pc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instruction(instruction),
    .LoadIR     (LoadIR),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .jump_en    (jump_en),
    .jump_cond  (jump_cond),
    .acc_zero   (acc_zero),
    .jump_target(jump_target),
    .halt       (halt),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
  );

  typedef struct packed {
    logic       run;
    logic       ack;
    logic [7:0] data;
    logic       done;
    logic       jen;
    logic       jcond;
    logic       azero;
    logic [7:0] jtgt;
    logic       hlt;
    // expected: req, addr, LoadIR, exec_start, instruction, pc, busy, halted
    logic       eReq;
    logic [7:0] eAddr;
    logic       eLd;
    logic       eXs;
    logic [7:0] eInstr;
    logic [7:0] ePc;
    logic       eBusy;
    logic       eHalted;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    run = 1'b0; imem_ack = 1'b0; imem_data = 8'h00; exec_done = 1'b0;
    jump_en = 1'b0; jump_cond = 1'b0; acc_zero = 1'b0; jump_target = 8'h00; halt = 1'b0;
  endtask

  task automatic doReset();
    clearIn();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // From IDLE: fetch one byte, execute it as an unconditional jump; ends in FETCH at target.
  task automatic startAndJump(input logic [7:0] target);
    run = 1'b1;
    tick();
    imem_ack = 1'b1; imem_data = 8'h00;
    tick();
    imem_ack = 1'b0;
    tick();
    exec_done = 1'b1; jump_en = 1'b1; jump_target = target;
    tick();
    exec_done = 1'b0; jump_en = 1'b0; jump_target = 8'h00;
  endtask

  initial begin
    int ldCount;
    // run ack data done jen jcond az jtgt halt | req addr ld xs instr pc busy halted
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{1, 1, 8'h99, 1, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0};
    vecs[2]  = '{1, 1, 8'h11, 0, 0, 0, 0, 8'h00, 0,  1, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0};
    vecs[3]  = '{1, 1, 8'h55, 0, 0, 0, 0, 8'h00, 0,  0, 8'h00, 1, 0, 8'h11, 8'h00, 1, 0};
    vecs[4]  = '{1, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0,  0, 8'h01, 0, 1, 8'h11, 8'h01, 1, 0};
    vecs[5]  = '{1, 1, 8'h22, 0, 0, 0, 0, 8'h00, 0,  1, 8'h01, 0, 0, 8'h11, 8'h01, 1, 0};
    vecs[6]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h01, 1, 0, 8'h22, 8'h01, 1, 0};
    vecs[7]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h02, 0, 1, 8'h22, 8'h02, 1, 0};
    vecs[8]  = '{1, 0, 8'h00, 1, 1, 0, 0, 8'h0A, 0,  0, 8'h02, 0, 0, 8'h22, 8'h02, 1, 0};
    vecs[9]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  1, 8'h0A, 0, 0, 8'h22, 8'h0A, 1, 0};
    vecs[10] = '{1, 1, 8'h33, 0, 0, 0, 0, 8'h00, 0,  1, 8'h0A, 0, 0, 8'h22, 8'h0A, 1, 0};
    vecs[11] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h0A, 1, 0, 8'h33, 8'h0A, 1, 0};
    vecs[12] = '{1, 0, 8'h00, 1, 1, 1, 0, 8'h03, 0,  0, 8'h0B, 0, 1, 8'h33, 8'h0B, 1, 0};
    vecs[13] = '{1, 1, 8'h44, 0, 0, 0, 0, 8'h00, 0,  1, 8'h0B, 0, 0, 8'h33, 8'h0B, 1, 0};
    vecs[14] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h0B, 1, 0, 8'h44, 8'h0B, 1, 0};
    vecs[15] = '{0, 0, 8'h00, 1, 1, 1, 1, 8'h07, 0,  0, 8'h0C, 0, 1, 8'h44, 8'h0C, 1, 0};
    vecs[16] = '{0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0,  0, 8'h07, 0, 0, 8'h44, 8'h07, 0, 0};
    vecs[17] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h07, 0, 0, 8'h44, 8'h07, 0, 0};
    vecs[18] = '{1, 1, 8'h66, 0, 0, 0, 0, 8'h00, 0,  1, 8'h07, 0, 0, 8'h44, 8'h07, 1, 0};
    vecs[19] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h07, 1, 0, 8'h66, 8'h07, 1, 0};
    vecs[20] = '{1, 0, 8'h00, 1, 1, 0, 0, 8'h01, 1,  0, 8'h08, 0, 1, 8'h66, 8'h08, 1, 0};
    vecs[21] = '{1, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0,  0, 8'h08, 0, 0, 8'h66, 8'h08, 0, 1};
    vecs[22] = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0,  0, 8'h08, 0, 0, 8'h66, 8'h08, 0, 1};

    reset = 1'b0;
    clearIn();
    #1;
    doReset();

    // Table: outputs depend only on state, so they are checked before the edge that
    // consumes this row's inputs.
    for (int i = 0; i < 23; i++) begin
      run = vecs[i].run; imem_ack = vecs[i].ack; imem_data = vecs[i].data;
      exec_done = vecs[i].done; jump_en = vecs[i].jen; jump_cond = vecs[i].jcond;
      acc_zero = vecs[i].azero; jump_target = vecs[i].jtgt; halt = vecs[i].hlt;
      #1;
      check($sformatf("vec%0d", i),
            32'({imem_req, imem_addr, LoadIR, exec_start, instruction, pc, busy, halted}),
            32'({vecs[i].eReq, vecs[i].eAddr, vecs[i].eLd, vecs[i].eXs, vecs[i].eInstr,
                 vecs[i].ePc, vecs[i].eBusy, vecs[i].eHalted}));
      tick();
    end

    // Memory wait: ack arrives in the 4th FETCH cycle at 0x05.
    doReset();
    startAndJump(8'h05);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wait_req%0d", i), 32'(imem_req), 32'd1);
      check($sformatf("wait_addr%0d", i), 32'(imem_addr), 32'h05);
      check($sformatf("wait_noload%0d", i), 32'(LoadIR), 32'd0);
      if (i == 3) begin
        imem_ack = 1'b1; imem_data = 8'h77;
      end
      tick();
    end
    imem_ack = 1'b0; run = 1'b0; exec_done = 1'b1;
    ldCount = 0;
    for (int i = 0; i < 4; i++) begin
      ldCount += int'(LoadIR);
      tick();
    end
    exec_done = 1'b0;
    check("wait_loadir_count", 32'(ldCount), 32'd1);
    check("wait_instr", 32'(instruction), 32'h77);
    check("wait_idle", 32'(busy), 32'd0);

    // PC wrap: fetch at 0xFF is followed by fetch at 0x00.
    doReset();
    startAndJump(8'hFF);
    check("wrap_addr_ff", 32'(imem_addr), 32'hFF);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    check("wrap_pc_00", 32'(pc), 32'h00);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr_00", 32'(imem_addr), 32'h00);

    // Run dropped during a 4-cycle EXEC: the instruction completes, then IDLE.
    doReset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1; imem_data = 8'h3C;
    tick();
    imem_ack = 1'b0;
    tick();
    check("rd_exec_start", 32'(exec_start), 32'd1);
    run = 1'b0;
    tick();
    check("rd_exec_start_once", 32'(exec_start), 32'd0);
    tick();
    tick();
    check("rd_busy_exec4", 32'(busy), 32'd1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_idle_req", 32'(imem_req), 32'd0);
    check("rd_pc", 32'(pc), 32'h01);
    tick();
    check("rd_stay_idle", 32'(imem_req | busy), 32'd0);

    // Reset mid-FETCH, with an ack in the same cycle that must be discarded.
    doReset();
    startAndJump(8'h09);
    check("rst_in_fetch", 32'(imem_req), 32'd1);
    reset = 1'b1; imem_ack = 1'b1; imem_data = 8'hAB;
    tick();
    reset = 1'b0; imem_ack = 1'b0;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_instr", 32'(instruction), 32'h00);
    check("rst_strobes", 32'({LoadIR, exec_start}), 32'd0);
    tick();
    check("rst_after_strobes", 32'({LoadIR, exec_start}), 32'd0);
    check("rst_refetch_addr", 32'({imem_req, imem_addr}), 32'h100);

    // Halt together with jump: HALTED, PC unchanged, run ignored.
    doReset();
    startAndJump(8'h04);
    imem_ack = 1'b1; imem_data = 8'hF0;
    tick();
    imem_ack = 1'b0;
    tick();
    exec_done = 1'b1; halt = 1'b1; jump_en = 1'b1; jump_target = 8'h0A;
    tick();
    exec_done = 1'b0; halt = 1'b0; jump_en = 1'b0;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    run = 1'b1; imem_ack = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("halt_noreq%0d", i), 32'(imem_req), 32'd0);
      check($sformatf("halt_pc%0d", i), 32'(pc), 32'h05);
    end
    check("halt_still", 32'(halted), 32'd1);
    doReset();
    check("halt_reset_exit", 32'({halted, busy}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
